// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: one WIDTH/STAGES-bit carry chunk resolved per stage,
// lock-step valid/ready flow control with no bubble collapsing.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int C = WIDTH / STAGES;

    logic adv;

    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [STAGES-1:0] am_q, am_d;
    logic [STAGES-1:0] bm_q, bm_d;
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];

    // Per-stage inputs: stage 0 sees the ports, stage k sees stage k-1.
    logic [WIDTH-1:0]  a_in [STAGES];
    logic [WIDTH-1:0]  b_in [STAGES];
    logic [WIDTH-1:0]  s_in [STAGES];
    logic [STAGES-1:0] c_in, v_in, am_in, bm_in;
    logic [C:0]        part;

    assign adv      = out_ready || !out_valid;
    assign in_ready = adv;

    always_comb begin
        a_in[0]  = A;
        b_in[0]  = sub ? ~B : B;
        s_in[0]  = '0;
        c_in[0]  = sub ? 1'b1 : cin;
        v_in[0]  = in_valid;
        am_in[0] = A[WIDTH-1];
        bm_in[0] = b_in[0][WIDTH-1];
        for (int k = 1; k < STAGES; k++) begin
            a_in[k]  = a_q[k-1];
            b_in[k]  = b_q[k-1];
            s_in[k]  = s_q[k-1];
            c_in[k]  = c_q[k-1];
            v_in[k]  = v_q[k-1];
            am_in[k] = am_q[k-1];
            bm_in[k] = bm_q[k-1];
        end
    end

    always_comb begin
        v_d  = v_q;
        c_d  = c_q;
        am_d = am_q;
        bm_d = bm_q;
        part = '0;
        for (int k = 0; k < STAGES; k++) begin
            s_d[k] = s_q[k];
            a_d[k] = a_q[k];
            b_d[k] = b_q[k];
            if (adv) begin
                part = {1'b0, a_in[k][k*C +: C]}
                     + {1'b0, b_in[k][k*C +: C]}
                     + {{C{1'b0}}, c_in[k]};
                s_d[k]           = s_in[k];
                s_d[k][k*C +: C] = part[C-1:0];
                c_d[k]           = part[C];
                a_d[k]           = a_in[k];
                b_d[k]           = b_in[k];
                v_d[k]           = v_in[k];
                am_d[k]          = am_in[k];
                bm_d[k]          = bm_in[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q  <= '0;
            c_q  <= '0;
            am_q <= '0;
            bm_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= '0;
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            v_q  <= v_d;
            c_q  <= c_d;
            am_q <= am_d;
            bm_q <= bm_d;
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= s_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = (am_q[STAGES-1] == bm_q[STAGES-1])
                    && (sum[WIDTH-1] != am_q[STAGES-1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: random and directed operations with
// random backpressure, mid-flight reset, and STAGES=1/16 latency sweeps.
module tb_pipelined_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] A, B;
    logic        cin, sub;
    logic        out_valid, out_ready;
    logic [15:0] sum;
    logic        cout, ovf;

    logic [15:0] sw_A, sw_B;
    logic        sw_cin, sw_sub;
    logic        v1, r1, ov1, co1, of1;
    logic        v16, r16, ov16, co16, of16;
    logic [15:0] s1, s16;

    int checks = 0;
    int errors = 0;

    logic [17:0] sbq[$];
    logic [17:0] exp_cur;
    logic [17:0] prev;
    bit          prev_stall = 0;
    bit          rand_mode = 0;

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipelined_adder #(.WIDTH(16), .STAGES(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v1), .in_ready(r1),
        .A(sw_A), .B(sw_B), .cin(sw_cin), .sub(sw_sub),
        .out_valid(ov1), .out_ready(1'b1),
        .sum(s1), .cout(co1), .ovf(of1)
    );

    pipelined_adder #(.WIDTH(16), .STAGES(16)) u16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v16), .in_ready(r16),
        .A(sw_A), .B(sw_B), .cin(sw_cin), .sub(sw_sub),
        .out_valid(ov16), .out_ready(1'b1),
        .sum(s16), .cout(co16), .ovf(of16)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Reference: plain integer arithmetic; result packed as {cout, ovf, sum}.
    function automatic logic [17:0] model(input logic [15:0] a, b,
                                          input logic c, s);
        int sa, sb, r;
        logic [16:0] u;
        logic co;
        sa = $signed(a);
        sb = $signed(b);
        if (s) begin
            u  = {1'b0, a} - {1'b0, b};
            co = (a >= b);
            r  = sa - sb;
        end else begin
            u  = {1'b0, a} + {1'b0, b} + {16'd0, c};
            co = u[16];
            r  = sa + sb + int'(c);
        end
        return {co, (r > 32767 || r < -32768), u[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) sbq.push_back(exp_cur);
            if (prev_stall)
                check("stall_hold", {13'd0, out_valid, cout, ovf, sum},
                      {13'd0, 1'b1, prev});
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out actual=%h required=none",
                             {cout, ovf, sum});
                end else begin
                    check("result", {14'd0, cout, ovf, sum},
                          {14'd0, sbq.pop_front()});
                end
            end
            prev_stall = out_valid && !out_ready;
            if (prev_stall) check("stall_in_ready", {31'd0, in_ready}, 0);
            prev = {cout, ovf, sum};
        end else begin
            prev_stall = 0;
        end
    end

    task automatic send(input logic [15:0] a, b, input logic c, s,
                        input logic [17:0] e);
        int n;
        bit ok;
        n = 0;
        A = a; B = b; cin = c; sub = s; exp_cur = e;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            ok = in_ready;
            if (!ok) begin
                A   = 16'($urandom);
                B   = 16'($urandom);
                cin = 1'($urandom);
                sub = 1'($urandom);
            end
            @(posedge clk);
            #1;
            if (ok) break;
            A = a; B = b; cin = c; sub = s;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout actual=stalled required=accept");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", {31'd0, (n >= 500)}, 0);
    endtask

    task automatic sweep(input int which, input logic [15:0] a, b,
                         input logic [17:0] e, input int lat);
        int n;
        sw_A = a; sw_B = b; sw_cin = 1'b0; sw_sub = 1'b0;
        check("sweep_ready", {31'd0, (which == 1) ? r1 : r16}, 1);
        if (which == 1) v1 = 1'b1;
        else v16 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        v16 = 1'b0;
        n = 0;
        while (!((which == 1) ? ov1 : ov16) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("sweep_latency", n, lat);
        if (which == 1) check("sweep_s1", {14'd0, co1, of1, s1}, {14'd0, e});
        else check("sweep_s16", {14'd0, co16, of16, s16}, {14'd0, e});
    endtask

    initial begin
        int n;
        logic [15:0] ra, rb;
        logic rc, rs;
        rst_n = 0;
        in_valid = 0;
        A = 0; B = 0; cin = 0; sub = 0; exp_cur = 0;
        sw_A = 0; sw_B = 0; sw_cin = 0; sw_sub = 0;
        v1 = 0; v16 = 0;
        #2;
        check("reset_out", {28'd0, out_valid, cout, ovf, in_ready}, 1);
        check("reset_sum", {16'd0, sum}, 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        send(16'h1234, 16'h1111, 1'b1, 1'b0, {1'b0, 1'b0, 16'h2346});
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency4", n, 3);
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, {1'b1, 1'b0, 16'h0000});
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
        send(16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        send(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
        wait_drain();

        rand_mode = 1;
        repeat (20) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        wait_drain();
        rand_mode = 0;
        @(posedge clk);
        #2;

        repeat (3) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            send(ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0));
        end
        rst_n = 0;
        #1;
        check("midreset_out", {29'd0, out_valid, cout, ovf}, 0);
        check("midreset_sum", {16'd0, sum}, 0);
        sbq.delete();
        @(posedge clk);
        #1;
        rst_n = 1;
        repeat (6) begin
            @(negedge clk);
            check("no_stale", {31'd0, out_valid}, 0);
        end
        @(posedge clk);
        #1;
        send(16'h0001, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0002});
        wait_drain();

        sweep(1, 16'hFFFF, 16'h0001, {1'b1, 1'b0, 16'h0000}, 0);
        sweep(1, 16'hAAAA, 16'h5555, {1'b0, 1'b0, 16'hFFFF}, 0);
        sweep(16, 16'hFFFF, 16'h0001, {1'b1, 1'b0, 16'h0000}, 15);
        sweep(16, 16'hAAAA, 16'h5555, {1'b0, 1'b0, 16'hFFFF}, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined two's-complement adder/subtractor that splits a WIDTH-bit add into STAGES equal chunks, with one chunk's carry resolved per pipeline stage. It is the registered successor to the 4-bit ripple adder: it has a configurable width and depth, an add/subtract mode, signed-overflow detection, and valid/ready flow control on both sides. It sits on datapath streams that need one add per cycle at a clock rate a full-width ripple chain cannot meet.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (≥1). Chunk width C = WIDTH/STAGES.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  A/B/cin/sub hold a valid operation.
- in_ready  output  1  the block accepts an operation this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: A+B+cin; 1: A−B (computed as A+~B+1; cin ignored).
- out_valid  output  1  sum/cout/ovf hold a valid result.
- out_ready  input  1  the downstream consumer takes the result this cycle.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB. For sub=1, 1 means no borrow (A≥B unsigned).
- ovf  output  1  signed overflow: the operand-MSB signs match (after inversion for sub) and differ from the sum MSB.

## Operation
- Accept: an operation is accepted on a rising edge where in_valid && in_ready.
- Global advance: adv = out_ready || !out_valid. in_ready = adv. All stages shift together when adv=1 and hold when adv=0 (no bubble collapsing).
- Stage k (0..STAGES−1): adds chunk k of A and B_eff (B_eff = sub ? ~B : B) plus the carry registered by stage k−1. The stage-0 carry is sub ? 1 : cin.
- Each stage registers:
  - its valid bit;
  - the completed lower sum chunks;
  - the not-yet-added upper A/B_eff chunks;
  - the carry-out;
  - sign bits A[WIDTH−1] and B_eff[WIDTH−1] for ovf.
- Final stage: drives sum, cout = last chunk carry, and ovf = (a_msb==b_msb) && (sum[WIDTH−1]!=a_msb).
- Bubbles: a valid bit of 0 propagates as a bubble. Datapath registers may update on bubbles, but the outputs are qualified only by out_valid.
- Operands are sampled only at the accept edge. Changes to A/B/cin/sub while in_ready=0 have no effect.

## Timing
- Reset (rst_n low, asynchronous): all stage valid bits are 0; out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 combinationally once the valid bits are 0.
- Reset mid-operation: all in-flight operations are discarded with no partial output. After release, the first accept is legal on the first rising edge.
- Latency: an operation accepted at edge t appears with out_valid=1 after edge t+STAGES−1 when no stall occurs. STAGES=1 therefore gives a registered adder with results visible the cycle after accept.
- Throughput: one operation per cycle while out_ready=1.
- Backpressure: with out_valid=1 && out_ready=0, the block holds sum/cout/ovf/out_valid stable and holds in_ready=0. Nothing is lost and nothing is duplicated.
- Simultaneous events: out_valid && out_ready with in_valid in the same cycle means one result leaves and one operation enters on the same edge.
- Wrap-around: sum wraps modulo 2^WIDTH and cout reports the carry. For example, 0xFFFF+0x0001 gives sum=0x0000, cout=1.
- Ordering: results leave in strict acceptance order.

## Test plan
All scenarios use WIDTH=16, STAGES=4.
- Basic add: A=0x1234, B=0x1111, cin=1, sub=0, out_ready=1 → after 4 edges, out_valid=1, sum=0x2346, cout=0, ovf=0.
- Carry ripple across all chunks: A=0xFFFF, B=0x0000, cin=1 → sum=0x0000, cout=1, ovf=0. Then A=0x7FFF, B=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1.
- Subtract: A=0x0005, B=0x0007, sub=1, cin=1 (must be ignored) → sum=0xFFFE, cout=0, ovf=0. Then A=0x8000, B=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
- Streaming with backpressure: 20 back-to-back random operations, with out_ready toggled pseudo-randomly → every result matches the reference model in order. While out_valid && !out_ready, the outputs stay stable and in_ready=0; no drops or duplicates.
- Reset mid-flight: accept 3 operations, assert rst_n low for 1 cycle before any output → out_valid=0, sum=0, cout=0, ovf=0 immediately. No stale result appears afterwards, and a new op A=0x0001, B=0x0001 returns sum=0x0002.
- Parameter sweep: STAGES=1 (latency 1) and STAGES=16 (C=1, latency 16), each with exhaustive carry-chain vectors 0xFFFF+0x0001 and 0xAAAA+0x5555 → results and latency as specified.
